// File: rtl/chroma_pkg.sv
// Shared types and constants for the 4:2:2 -> 4:4:4 chroma job sequencer.
package chroma_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } seq_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_ABORT   = 2'd3
   } err_code_e;

   localparam int unsigned BYTES_PER_BEAT = 32'd8;
   localparam int unsigned OUT_EXPANSION  = 32'd2;

   // True when a byte address or length is not a whole 8-byte word.
   function automatic logic misaligned(input logic [2:0] low_bits);
      return (low_bits != 3'd0);
   endfunction

endpackage

// File: rtl/chroma_cmd_slot.sv
// Single mover command slot: holds valid until handshake, records that the command went out.
module chroma_cmd_slot (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic ready,
   input  logic abort,
   output logic valid,
   output logic sent
);

   logic valid_r;
   logic sent_r;

   // Raise valid on load, retire it on handshake; abort wipes the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         sent_r  <= 1'b0;
      end else if (abort) begin
         valid_r <= 1'b0;
         sent_r  <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         sent_r  <= 1'b0;
      end else if (valid_r && ready) begin
         valid_r <= 1'b0;
         sent_r  <= 1'b1;
      end else begin
         valid_r <= valid_r;
         sent_r  <= sent_r;
      end
   end

   // An abort withdraws a pending command in the same cycle so it cannot handshake.
   assign valid = valid_r & ~abort;
   assign sent  = sent_r;

endmodule

// File: rtl/chroma_job_sequencer.sv
// Splits a chroma conversion job into chunks, issues read/write mover commands per chunk
// and tracks converter output beats until each chunk, then the job, completes.
module chroma_job_sequencer
   import chroma_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32'd64,
   parameter int LEN_WIDTH   = 32'd32,
   parameter int CHUNK_BYTES = 32'd128,
   parameter int TIMEOUT     = 32'd1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [ADDR_WIDTH-1:0] job_src,
   input  logic [ADDR_WIDTH-1:0] job_dst,
   input  logic [LEN_WIDTH-1:0]  job_len,
   input  logic                  abort,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH-1:0] rd_src,
   output logic [LEN_WIDTH-1:0]  rd_len,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_dest,
   input  logic                  mon_valid,
   input  logic                  mon_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code
);

   localparam int TMR_W = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 32'sd1;
   localparam logic [TMR_W-1:0] TMR_LAST =
      (TIMEOUT > 32'sd0) ? TMR_W'(TIMEOUT - 32'sd1) : {TMR_W{1'b0}};
   localparam logic [LEN_WIDTH-1:0] CHUNK_MAX = LEN_WIDTH'(CHUNK_BYTES);
   // Each 8-byte input word expands to two 8-byte output beats: beats = bytes / 4.
   localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT / OUT_EXPANSION);

   seq_state_e            state_r, state_nxt_s;
   err_code_e             err_code_r;
   logic [ADDR_WIDTH-1:0] cur_src_r, cur_dst_r, rd_src_r, wr_dest_r;
   logic [ADDR_WIDTH-1:0] next_src_s, next_dst_s;
   logic [LEN_WIDTH-1:0]  rem_r, rd_len_r, beat_cnt_r, next_rem_s;
   logic [TMR_W-1:0]      timer_r;
   logic                  job_ready_r, busy_r, done_r, error_r;
   logic                  accept_s, bad_s, load_s, to_wait_s, beat_s, chunk_end_s;
   logic                  timeout_s, abort_s, rd_sent_s, wr_sent_s;

   function automatic logic [LEN_WIDTH-1:0] chunk_of(input logic [LEN_WIDTH-1:0] len);
      return (len > CHUNK_MAX) ? CHUNK_MAX : len;
   endfunction

   assign abort_s    = abort & ((state_r == S_ISSUE) || (state_r == S_WAIT));
   assign next_rem_s = rem_r - rd_len_r;
   assign next_src_s = cur_src_r + ADDR_WIDTH'(rd_len_r);
   assign next_dst_s = cur_dst_r + ADDR_WIDTH'(rd_len_r) * ADDR_WIDTH'(OUT_EXPANSION);

   chroma_cmd_slot u_rd_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s),
      .ready (rd_ready),
      .abort (abort_s),
      .valid (rd_valid),
      .sent  (rd_sent_s)
   );

   chroma_cmd_slot u_wr_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s),
      .ready (wr_ready),
      .abort (abort_s),
      .valid (wr_valid),
      .sent  (wr_sent_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; abort outranks beats and handshakes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      bad_s       = 1'b0;
      load_s      = 1'b0;
      to_wait_s   = 1'b0;
      beat_s      = 1'b0;
      chunk_end_s = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (job_valid && job_ready_r) begin
               accept_s = 1'b1;
               if ((job_len == {LEN_WIDTH{1'b0}}) || misaligned(job_len[2:0]) ||
                   misaligned(job_src[2:0]) || misaligned(job_dst[2:0])) begin
                  bad_s       = 1'b1;
                  state_nxt_s = S_ERR;
               end else begin
                  load_s      = 1'b1;
                  state_nxt_s = S_ISSUE;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (abort_s) begin
               state_nxt_s = S_ERR;
            end else if (rd_sent_s && wr_sent_s) begin
               to_wait_s   = 1'b1;
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_ISSUE;
            end
         end
         S_WAIT: begin
            if (abort_s) begin
               state_nxt_s = S_ERR;
            end else if (mon_valid && mon_ready) begin
               beat_s = 1'b1;
               if (beat_cnt_r == LEN_WIDTH'(1)) begin
                  chunk_end_s = 1'b1;
                  if (next_rem_s == {LEN_WIDTH{1'b0}}) begin
                     state_nxt_s = S_DONE;
                  end else begin
                     load_s      = 1'b1;
                     state_nxt_s = S_ISSUE;
                  end
               end else begin
                  state_nxt_s = S_WAIT;
               end
            end else if ((TIMEOUT > 32'sd0) && (timer_r == TMR_LAST)) begin
               timeout_s   = 1'b1;
               state_nxt_s = S_ERR;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         S_ERR:   state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Registered status flags, error code, chunk bookkeeping and idle timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         job_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         err_code_r  <= ERR_NONE;
         cur_src_r   <= {ADDR_WIDTH{1'b0}};
         cur_dst_r   <= {ADDR_WIDTH{1'b0}};
         rd_src_r    <= {ADDR_WIDTH{1'b0}};
         wr_dest_r   <= {ADDR_WIDTH{1'b0}};
         rem_r       <= {LEN_WIDTH{1'b0}};
         rd_len_r    <= {LEN_WIDTH{1'b0}};
         beat_cnt_r  <= {LEN_WIDTH{1'b0}};
         timer_r     <= {TMR_W{1'b0}};
      end else begin
         job_ready_r <= (state_nxt_s == S_IDLE);
         busy_r      <= (state_nxt_s == S_ISSUE) || (state_nxt_s == S_WAIT);
         done_r      <= (state_nxt_s == S_DONE);
         error_r     <= (state_nxt_s == S_ERR);

         if (accept_s) begin
            err_code_r <= bad_s ? ERR_LEN : ERR_NONE;
         end else if (abort_s) begin
            err_code_r <= ERR_ABORT;
         end else if (timeout_s) begin
            err_code_r <= ERR_TIMEOUT;
         end else begin
            err_code_r <= err_code_r;
         end

         if (accept_s && !bad_s) begin
            cur_src_r <= job_src;
            cur_dst_r <= job_dst;
            rem_r     <= job_len;
            rd_src_r  <= job_src;
            wr_dest_r <= job_dst;
            rd_len_r  <= chunk_of(job_len);
         end else if (chunk_end_s) begin
            cur_src_r <= next_src_s;
            cur_dst_r <= next_dst_s;
            rem_r     <= next_rem_s;
            if (load_s) begin
               rd_src_r  <= next_src_s;
               wr_dest_r <= next_dst_s;
               rd_len_r  <= chunk_of(next_rem_s);
            end else begin
               rd_len_r  <= rd_len_r;
            end
         end else begin
            rem_r <= rem_r;
         end

         if (to_wait_s) begin
            beat_cnt_r <= rd_len_r >> BEAT_SHIFT;
         end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r - LEN_WIDTH'(1);
         end else begin
            beat_cnt_r <= beat_cnt_r;
         end

         if ((state_r == S_WAIT) && (state_nxt_s == S_WAIT) && !beat_s) begin
            timer_r <= timer_r + TMR_W'(1);
         end else begin
            timer_r <= {TMR_W{1'b0}};
         end
      end
   end

   assign job_ready = job_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign err_code  = err_code_r;
   assign rd_src    = rd_src_r;
   assign rd_len    = rd_len_r;
   assign wr_dest   = wr_dest_r;

endmodule

// File: tb/tb_chroma_job_sequencer.sv
// Self-checking bench: acts as read/write movers and converter, checks commands and
// completion against a chunk-list model built from the job parameters.
module tb_chroma_job_sequencer;

   localparam int AW    = 64;
   localparam int LW    = 32;
   localparam int CHUNK = 128;
   localparam int TMO   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          job_valid, job_ready, abort;
   logic [AW-1:0] job_src, job_dst, rd_src, wr_dest;
   logic [LW-1:0] job_len, rd_len;
   logic          rd_valid, rd_ready, wr_valid, wr_ready, mon_valid, mon_ready;
   logic          busy, done, error;
   logic [1:0]    err_code;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chroma_job_sequencer #(
      .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CHUNK_BYTES(CHUNK), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .job_src(job_src), .job_dst(job_dst), .job_len(job_len), .abort(abort),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_src(rd_src), .rd_len(rd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dest(wr_dest),
      .mon_valid(mon_valid), .mon_ready(mon_ready),
      .busy(busy), .done(done), .error(error), .err_code(err_code)
   );

   function automatic logic [AW-1:0] rand_addr();
      return {$urandom, $urandom} & ~64'h7;
   endfunction

   task automatic submit(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len);
      int n = 0;
      while (job_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (job_ready !== 1'b1) begin
         errors++;
         $display("FAIL submit_ready: job_ready=%b expected 1", job_ready);
      end
      job_src = src; job_dst = dst; job_len = len; job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   // Accept both commands at once, then step to the first cycle where beats count.
   task automatic enter_wait();
      rd_ready = 1'b1; wr_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0; wr_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [LW-1:0] len, input int rd_stall_in);
      logic [AW-1:0] e_src[$];
      logic [AW-1:0] e_dst[$];
      logic [LW-1:0] e_len[$];
      logic [LW-1:0] off, c;
      int n, k, beats_left, delay, rd_stall;
      bit rd_done, wr_done, phase, exp_done, finished;
      off = '0;
      while (off < len) begin
         c = ((len - off) > LW'(CHUNK)) ? LW'(CHUNK) : (len - off);
         e_src.push_back(src + {32'd0, off});
         e_dst.push_back(dst + {32'd0, off} * 64'd2);
         e_len.push_back(c);
         off = off + c;
      end
      n = e_src.size();
      rd_stall = rd_stall_in;
      submit(src, dst, len);
      k = 0; rd_done = 0; wr_done = 0; phase = 0; exp_done = 0; finished = 0; delay = 0;
      beats_left = int'(e_len[0] / 4);
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         checks++;
         if (done !== exp_done || error !== 1'b0) begin
            errors++;
            $display("FAIL job_done: done=%b error=%b expected done=%b error=0 cyc=%0d",
                     done, error, exp_done, cyc);
         end
         if (exp_done) begin
            mon_valid = 1'b0; mon_ready = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
            checks++;
            if (err_code !== 2'd0) begin
               errors++;
               $display("FAIL job_err_code: err_code=%0d expected 0", err_code);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || job_ready !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL job_idle: busy=%b job_ready=%b done=%b expected 0 1 0",
                        busy, job_ready, done);
            end
            finished = 1;
         end else begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL job_busy: busy=%b expected 1 cyc=%0d", busy, cyc);
            end
            mon_valid = 1'b0; mon_ready = 1'b0;
            if (phase) begin
               if (delay > 0) delay--;
               if (delay == 0 && $urandom_range(0, 2) != 0) begin
                  mon_valid = 1'b1; mon_ready = 1'b1;
                  beats_left--;
                  if (beats_left == 0) begin
                     k++; phase = 0; rd_done = 0; wr_done = 0;
                     if (k == n) exp_done = 1;
                     else beats_left = int'(e_len[k] / 4);
                  end
               end else begin
                  mon_valid = ($urandom_range(0, 1) == 1);
               end
            end else begin
               // Beats outside the waiting phase must be ignored by the sequencer.
               mon_valid = ($urandom_range(0, 3) == 0);
               mon_ready = ($urandom_range(0, 1) == 1);
            end
            rd_ready = 1'b0;
            if (rd_valid === 1'b1) begin
               checks++;
               if (rd_done || k >= n) begin
                  errors++;
                  $display("FAIL rd_extra: rd_valid=1 expected 0 chunk=%0d", k);
               end else if (rd_stall > 0) begin
                  rd_stall--;
                  if (rd_src !== e_src[k] || rd_len !== e_len[k]) begin
                     errors++;
                     $display("FAIL rd_hold: rd_src=%h rd_len=%0d expected %h %0d",
                              rd_src, rd_len, e_src[k], e_len[k]);
                  end
               end else begin
                  rd_ready = ($urandom_range(0, 3) != 0);
                  if (rd_ready) begin
                     rd_done = 1;
                     if (rd_src !== e_src[k] || rd_len !== e_len[k]) begin
                        errors++;
                        $display("FAIL rd_cmd: rd_src=%h rd_len=%0d expected %h %0d",
                                 rd_src, rd_len, e_src[k], e_len[k]);
                     end
                  end
               end
            end
            wr_ready = 1'b0;
            if (wr_valid === 1'b1) begin
               checks++;
               if (wr_done || k >= n) begin
                  errors++;
                  $display("FAIL wr_extra: wr_valid=1 expected 0 chunk=%0d", k);
               end else begin
                  wr_ready = (rd_stall_in > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                  if (wr_ready) begin
                     wr_done = 1;
                     if (wr_dest !== e_dst[k]) begin
                        errors++;
                        $display("FAIL wr_cmd: wr_dest=%h expected %h", wr_dest, e_dst[k]);
                     end
                  end
               end
            end
            if (rd_done && wr_done && !phase) begin
               phase = 1; delay = 2;
            end
            @(negedge clk);
         end
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL job_timeout: job did not complete, chunk=%0d of %0d", k, n);
      end
      mon_valid = 1'b0; mon_ready = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (job_ready !== 1'b1 || rd_valid !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || rd_src !== 64'd0 ||
          rd_len !== 32'd0 || wr_dest !== 64'd0) begin
         errors++;
         $display("FAIL reset_values: ready=%b rv=%b wv=%b busy=%b done=%b err=%b code=%0d src=%h len=%0d dst=%h",
                  job_ready, rd_valid, wr_valid, busy, done, error, err_code, rd_src, rd_len, wr_dest);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_bad_job();
      logic [AW-1:0] s, d;
      logic [LW-1:0] l;
      for (int i = 0; i < 8; i++) begin
         s = rand_addr(); d = rand_addr(); l = LW'(8 * $urandom_range(1, 40));
         case (i % 4)
            0: l = (i == 0) ? 32'd12 : (l | LW'($urandom_range(1, 7)));
            1: l = 32'd0;
            2: s = (i == 2) ? 64'd4 : (s | 64'($urandom_range(1, 7)));
            default: d = d | 64'($urandom_range(1, 7));
         endcase
         submit(s, d, l);
         checks++;
         if (error !== 1'b1 || err_code !== 2'd1 || rd_valid !== 1'b0 ||
             wr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_job: error=%b code=%0d rv=%b wv=%b busy=%b expected 1 1 0 0 0",
                     error, err_code, rd_valid, wr_valid, busy);
         end
         @(negedge clk);
         checks++;
         if (error !== 1'b0 || job_ready !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL bad_job_after: error=%b ready=%b code=%0d expected 0 1 1",
                     error, job_ready, err_code);
         end
      end
   endtask

   task automatic test_timeout();
      submit(rand_addr(), rand_addr(), 32'd128);
      enter_wait();
      mon_valid = 1'b1; mon_ready = 1'b1;
      repeat (5) @(negedge clk);
      mon_valid = 1'b0; mon_ready = 1'b0;
      for (int i = 0; i <= TMO; i++) begin
         checks++;
         if (error !== (i == TMO)) begin
            errors++;
            $display("FAIL timeout_pulse: error=%b expected %b after %0d idle cycles",
                     error, (i == TMO), i);
         end
         if (i != TMO) @(negedge clk);
      end
      checks++;
      if (err_code !== 2'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_code: err_code=%0d busy=%b expected 2 0", err_code, busy);
      end
   endtask

   task automatic test_abort();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (job_ready !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: ready=%b error=%b busy=%b expected 1 0 0", job_ready, error, busy);
      end
      submit(rand_addr(), rand_addr(), 32'd256);
      rd_ready = 1'b1; wr_ready = 1'b1; abort = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_drop: rd_valid=%b wr_valid=%b expected 0 0", rd_valid, wr_valid);
      end
      @(negedge clk);
      abort = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
      checks++;
      if (error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_issue: error=%b code=%0d busy=%b rv=%b expected 1 3 0 0",
                  error, err_code, busy, rd_valid);
      end
      submit(rand_addr(), rand_addr(), 32'd128);
      enter_wait();
      mon_valid = 1'b1; mon_ready = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0;
      checks++;
      if (error !== 1'b1 || err_code !== 2'd3 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_wait: error=%b code=%0d done=%b expected 1 3 0", error, err_code, done);
      end
   endtask

   task automatic test_reset_mid_job();
      logic [AW-1:0] s;
      submit(rand_addr(), rand_addr(), 32'd256);
      enter_wait();
      mon_valid = 1'b1; mon_ready = 1'b1;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (job_ready !== 1'b1 || rd_valid !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || rd_src !== 64'd0 ||
          rd_len !== 32'd0 || wr_dest !== 64'd0) begin
         errors++;
         $display("FAIL reset_async: ready=%b rv=%b wv=%b busy=%b code=%0d src=%h len=%0d dst=%h",
                  job_ready, rd_valid, wr_valid, busy, err_code, rd_src, rd_len, wr_dest);
      end
      mon_valid = 1'b0; mon_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      s = rand_addr();
      run_job(s, rand_addr(), 32'd192, 0);
   endtask

   task automatic test_random_jobs();
      logic [AW-1:0] s, d;
      for (int i = 0; i < 8; i++) begin
         s = (i == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : rand_addr();
         d = (i == 1) ? 64'hFFFF_FFFF_FFFF_FF00 : rand_addr();
         run_job(s, d, LW'(8 * $urandom_range(1, 70)), 0);
      end
   endtask

   initial begin
      rst = 1'b1; job_valid = 1'b0; job_src = '0; job_dst = '0; job_len = '0; abort = 1'b0;
      rd_ready = 1'b0; wr_ready = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0;
      test_reset();
      run_job(64'd0, 64'd8, 32'd128, 0);
      run_job(64'd0, 64'd8, 32'd320, 0);
      run_job(rand_addr(), rand_addr(), 32'd256, 10);
      test_bad_job();
      test_timeout();
      test_abort();
      test_reset_mid_job();
      test_random_jobs();
      run_job(rand_addr(), rand_addr(), 32'd8, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
